// File: rtl/proj_pkg.sv
// Shared definitions for the projection stream transmitter: defaults, word
// kind codes, FSM state encoding and the 32-bit word layout.
package proj_pkg;

  localparam int COLS_DEFAULT = 640;
  localparam int ROWS_DEFAULT = 480;

  localparam int WORD_W   = 32;
  localparam int KIND_LSB = 30;
  localparam int IDX_LSB  = 20;
  localparam int IDX_W    = 10;
  localparam int VAL_MAXW = 20;

  typedef enum logic [1:0] {
    KIND_HDR  = 2'b00,
    KIND_COL  = 2'b01,
    KIND_ROW  = 2'b10,
    KIND_CSUM = 2'b11
  } kind_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR    = 3'd1,
    ST_FETCH  = 3'd2,
    ST_RDWAIT = 3'd3,
    ST_REQ_HI = 3'd4,
    ST_REQ_LO = 3'd5,
    ST_CSUM   = 3'd6,
    ST_DONE   = 3'd7
  } state_e;

  function automatic logic [WORD_W-1:0] make_word(input kind_e k,
                                                  input logic [IDX_W-1:0] idx,
                                                  input logic [VAL_MAXW-1:0] val);
    return {k, idx, val};
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-stage flip-flop synchronizer for one asynchronous level input;
// every stage clears to 0 on reset.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  // NOTE: clocked state uses non-blocking assignments so every stage samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_sync <= '0;
    else          r_sync <= STAGES'({r_sync, i_d});
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/proj_stream_tx.sv
// Streams header, column sums, row sums and a checksum from the projection
// RAMs to the HPS, one word per 4-phase REQ/ACK handshake.
module proj_stream_tx
  import proj_pkg::*;
#(
  parameter int COLS        = COLS_DEFAULT,
  parameter int ROWS        = ROWS_DEFAULT,
  parameter int VAL_W       = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  input  logic             iSTART,
  input  logic             iABORT,
  input  logic             iACK,
  output logic             oRAM_SEL,
  output logic [9:0]       oRAM_ADDR,
  input  logic [VAL_W-1:0] iRAM_DATA,
  output logic [31:0]      oDATA,
  output logic             oREQ,
  output logic             oBUSY,
  output logic             oDONE,
  output logic [2:0]       oSTATE
);

  logic w_start_s, w_abort_s, w_ack_s;
  logic w_start_rise;
  logic [VAL_MAXW-1:0] w_val;
  kind_e w_last_kind;

  logic                r_start_prev;
  state_e              r_state;
  logic [IDX_W-1:0]    r_index;
  logic                r_sel;
  logic [VAL_MAXW-1:0] r_csum;
  logic [VAL_MAXW-1:0] r_seq;
  logic [WORD_W-1:0]   r_data;
  logic                r_req, r_busy, r_done;

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_start (.i_clk(iCLK), .i_rst_n(iRST_N), .i_d(iSTART), .o_q(w_start_s));
  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_abort (.i_clk(iCLK), .i_rst_n(iRST_N), .i_d(iABORT), .o_q(w_abort_s));
  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_ack   (.i_clk(iCLK), .i_rst_n(iRST_N), .i_d(iACK),   .o_q(w_ack_s));

  assign w_start_rise = w_start_s & ~r_start_prev;
  assign w_val        = VAL_MAXW'(iRAM_DATA);
  // The kind of the word just handshaked is still held in the output register.
  assign w_last_kind  = kind_e'(r_data[KIND_LSB +: 2]);

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_start_prev <= 1'b0;
      r_state      <= ST_IDLE;
      r_index      <= '0;
      r_sel        <= 1'b0;
      r_csum       <= '0;
      r_seq        <= '0;
      r_data       <= '0;
      r_req        <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_start_prev <= w_start_s;
      if (w_abort_s && r_state != ST_IDLE) begin
        r_req   <= 1'b0;
        r_busy  <= 1'b0;
        r_done  <= 1'b0;
        r_state <= ST_IDLE;
      end else begin
        unique case (r_state)
          ST_IDLE, ST_DONE: begin
            if (w_start_rise) begin
              r_csum  <= '0;
              r_index <= '0;
              r_sel   <= 1'b0;
              r_busy  <= 1'b1;
              r_done  <= 1'b0;
              r_state <= ST_HDR;
            end else if (r_state == ST_DONE && !w_start_s) begin
              r_done  <= 1'b0;
              r_state <= ST_IDLE;
            end
          end
          ST_HDR: begin
            r_data  <= make_word(KIND_HDR, '0, r_seq);
            r_req   <= 1'b1;
            r_state <= ST_REQ_HI;
          end
          ST_FETCH: r_state <= ST_RDWAIT;
          ST_RDWAIT: begin
            r_data  <= make_word(r_sel ? KIND_ROW : KIND_COL, r_index, w_val);
            r_csum  <= r_csum + w_val;
            r_req   <= 1'b1;
            r_state <= ST_REQ_HI;
          end
          ST_REQ_HI: begin
            if (w_ack_s) begin
              r_req   <= 1'b0;
              r_state <= ST_REQ_LO;
            end
          end
          ST_REQ_LO: begin
            if (!w_ack_s) begin
              unique case (w_last_kind)
                KIND_CSUM: begin
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_seq   <= r_seq + 20'd1;
                  r_state <= ST_DONE;
                end
                KIND_COL: begin
                  if (r_index == IDX_W'(COLS - 1)) begin
                    r_index <= '0;
                    r_sel   <= 1'b1;
                  end else begin
                    r_index <= r_index + 10'd1;
                  end
                  r_state <= ST_FETCH;
                end
                KIND_ROW: begin
                  if (r_index == IDX_W'(ROWS - 1)) begin
                    r_state <= ST_CSUM;
                  end else begin
                    r_index <= r_index + 10'd1;
                    r_state <= ST_FETCH;
                  end
                end
                KIND_HDR: begin
                  r_index <= '0;
                  r_state <= ST_FETCH;
                end
              endcase
            end
          end
          ST_CSUM: begin
            r_data  <= make_word(KIND_CSUM, '0, r_csum);
            r_req   <= 1'b1;
            r_state <= ST_REQ_HI;
          end
        endcase
      end
    end
  end

  assign oRAM_SEL  = r_sel;
  assign oRAM_ADDR = r_index;
  assign oDATA     = r_data;
  assign oREQ      = r_req;
  assign oBUSY     = r_busy;
  assign oDONE     = r_done;
  assign oSTATE    = r_state;

endmodule

// File: tb/tb_proj_stream_tx.sv
// Scoreboard bench for proj_stream_tx: stimulus queues expected words, a
// negedge monitor pops them on every oREQ rise and echoes ACK 3 cycles later.
module tb_proj_stream_tx;

  localparam int COLS  = 640;
  localparam int ROWS  = 480;
  localparam int VAL_W = 10;
  localparam int SYNC  = 2;
  localparam int WORDS = COLS + ROWS + 2;

  logic             iCLK = 1'b0;
  logic             iRST_N;
  logic             iSTART;
  logic             iABORT;
  logic             iACK = 1'b0;
  logic             oRAM_SEL;
  logic [9:0]       oRAM_ADDR;
  logic [VAL_W-1:0] iRAM_DATA;
  logic [31:0]      oDATA;
  logic             oREQ, oBUSY, oDONE;
  logic [2:0]       oSTATE;

  int          tests_run    = 0;
  int          tests_failed = 0;
  logic [31:0] exp_q[$];
  int          rx_cnt   = 0;
  logic        req_q    = 1'b0;
  logic [2:0]  ack_pipe = 3'b000;
  bit          stall_on = 1'b0;
  int          stall_at = 0;
  bit          ram_mode = 1'b0;

  proj_stream_tx #(.COLS(COLS), .ROWS(ROWS), .VAL_W(VAL_W), .SYNC_STAGES(SYNC)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iSTART(iSTART), .iABORT(iABORT), .iACK(iACK),
    .oRAM_SEL(oRAM_SEL), .oRAM_ADDR(oRAM_ADDR), .iRAM_DATA(iRAM_DATA),
    .oDATA(oDATA), .oREQ(oREQ), .oBUSY(oBUSY), .oDONE(oDONE), .oSTATE(oSTATE)
  );

  always #5 iCLK = ~iCLK;

  // RAM model: col[i]=i, row[j]=j, or every entry 1023; one-cycle read latency.
  always @(posedge iCLK) iRAM_DATA <= ram_mode ? 10'd1023 : oRAM_ADDR;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [1:0] k, input logic [9:0] idx, input logic [19:0] v);
    return {k, idx, v};
  endfunction

  task automatic push_transfer(input logic [19:0] seq, input bit all_max, input logic [19:0] csum);
    exp_q.push_back(mk(2'b00, 10'd0, seq));
    for (int c = 0; c < COLS; c++) exp_q.push_back(mk(2'b01, 10'(c), all_max ? 20'd1023 : 20'(c)));
    for (int r = 0; r < ROWS; r++) exp_q.push_back(mk(2'b10, 10'(r), all_max ? 20'd1023 : 20'(r)));
    exp_q.push_back(mk(2'b11, 10'd0, csum));
  endtask

  task automatic wait_rx(input int n, input int budget, input string name);
    int k = 0;
    while (rx_cnt < n && k < budget) begin
      @(negedge iCLK);
      k++;
    end
    check(name, 32'(rx_cnt >= n), 32'd1);
  endtask

  task automatic wait_state(input logic [2:0] st, input int budget, input string name);
    int k = 0;
    while (oSTATE !== st && k < budget) begin
      @(negedge iCLK);
      k++;
    end
    check(name, 32'(oSTATE), 32'(st));
  endtask

  // Monitor and ACK responder share one process so the stall decision sees
  // the word count updated on the same edge.
  always @(negedge iCLK) begin
    if (iRST_N === 1'b1 && oREQ === 1'b1 && req_q === 1'b0) begin
      rx_cnt++;
      if (exp_q.size() == 0) check("unexpected_word", oDATA, 32'hDEAD_BEEF);
      else                   check("word", oDATA, exp_q.pop_front());
    end
    req_q    = oREQ;
    ack_pipe = {ack_pipe[1:0], oREQ};
    iACK     = ack_pipe[2] && !(stall_on && rx_cnt == stall_at);
  end

  initial begin
    int bad;
    int base;
    iRST_N = 1'b0;
    iSTART = 1'b0;
    iABORT = 1'b0;
    repeat (3) @(negedge iCLK);
    check("rst_data",  oDATA, 32'd0);
    check("rst_req",   32'(oREQ), 32'd0);
    check("rst_busy",  32'(oBUSY), 32'd0);
    check("rst_done",  32'(oDONE), 32'd0);
    check("rst_state", 32'(oSTATE), 32'd0);
    check("rst_sel",   32'(oRAM_SEL), 32'd0);
    check("rst_addr",  32'(oRAM_ADDR), 32'd0);
    iRST_N = 1'b1;
    repeat (3) @(negedge iCLK);

    // Transfer 1: index ramp, ACK stall on word 5, extra START edge mid-run.
    stall_at = 5;
    stall_on = 1'b1;
    push_transfer(20'd0, 1'b0, 20'd319440);
    iSTART = 1'b1;
    wait_rx(5, 500, "reach_word5");
    bad = 0;
    repeat (1000) begin
      @(negedge iCLK);
      if (!(oREQ === 1'b1 && oDATA === mk(2'b01, 10'd3, 20'd3))) bad++;
    end
    check("stall_hold", 32'(bad), 32'd0);
    check("stall_rx_cnt", 32'(rx_cnt), 32'd5);
    stall_on = 1'b0;
    wait_rx(100, 5000, "reach_word100");
    iSTART = 1'b0;
    repeat (10) @(negedge iCLK);
    iSTART = 1'b1;
    repeat (6) @(negedge iCLK);
    check("busy_after_pulse", 32'(oBUSY), 32'd1);
    wait_state(3'd7, 30000, "t1_done_state");
    check("t1_done", 32'(oDONE), 32'd1);
    check("t1_busy", 32'(oBUSY), 32'd0);
    check("t1_count", 32'(rx_cnt), 32'(WORDS));
    check("t1_queue_empty", 32'(exp_q.size()), 32'd0);
    repeat (50) @(negedge iCLK);
    check("hold_start_no_restart", 32'(oSTATE), 32'd7);
    check("hold_start_count", 32'(rx_cnt), 32'(WORDS));
    iSTART = 1'b0;
    wait_state(3'd0, 20, "t1_idle");
    check("t1_done_clear", 32'(oDONE), 32'd0);

    // Transfer 2: every value 1023, checksum wraps mod 2^20.
    base = rx_cnt;
    ram_mode = 1'b1;
    push_transfer(20'd1, 1'b1, 20'd97184);
    iSTART = 1'b1;
    wait_state(3'd7, 30000, "t2_done_state");
    check("t2_count", 32'(rx_cnt - base), 32'(WORDS));
    check("t2_queue_empty", 32'(exp_q.size()), 32'd0);
    iSTART = 1'b0;
    wait_state(3'd0, 20, "t2_idle");

    // Transfer 3: abort while row word 4 is being requested.
    ram_mode = 1'b0;
    base = rx_cnt;
    stall_at = base + 646;
    stall_on = 1'b1;
    push_transfer(20'd2, 1'b0, 20'd319440);
    iSTART = 1'b1;
    wait_rx(base + 646, 20000, "reach_row4");
    check("abort_row_word", oDATA, mk(2'b10, 10'd4, 20'd4));
    iABORT = 1'b1;
    for (int k = 0; k < SYNC + 1; k++) begin
      @(negedge iCLK);
      if (oREQ === 1'b0) break;
    end
    check("abort_req_low", 32'(oREQ), 32'd0);
    check("abort_state", 32'(oSTATE), 32'd0);
    check("abort_busy", 32'(oBUSY), 32'd0);
    exp_q.delete();
    iABORT = 1'b0;
    stall_on = 1'b0;
    iSTART = 1'b0;
    repeat (20) @(negedge iCLK);
    check("abort_no_more_words", 32'(rx_cnt), 32'(base + 646));

    // Transfer 4: header must repeat seq=2, then async reset mid-word.
    base = rx_cnt;
    exp_q.push_back(mk(2'b00, 10'd0, 20'd2));
    exp_q.push_back(mk(2'b01, 10'd0, 20'd0));
    exp_q.push_back(mk(2'b01, 10'd1, 20'd1));
    stall_at = base + 3;
    stall_on = 1'b1;
    iSTART = 1'b1;
    wait_rx(base + 3, 500, "reach_t4_word3");
    @(negedge iCLK);
    #2 iRST_N = 1'b0;
    #1;
    check("arst_data",  oDATA, 32'd0);
    check("arst_req",   32'(oREQ), 32'd0);
    check("arst_busy",  32'(oBUSY), 32'd0);
    check("arst_done",  32'(oDONE), 32'd0);
    check("arst_state", 32'(oSTATE), 32'd0);
    check("arst_addr",  32'(oRAM_ADDR), 32'd0);
    check("arst_sel",   32'(oRAM_SEL), 32'd0);
    check("t4_queue_empty", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    stall_on = 1'b0;
    iSTART = 1'b0;
    @(negedge iCLK);
    iRST_N = 1'b1;
    repeat (5) @(negedge iCLK);
    check("post_rst_state", 32'(oSTATE), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/proj_stream_tx.md
# proj_stream_tx

Transmits the accumulated column and row projection sums (threshold-pixel counts per column and per row) from FPGA projection RAM to the HPS over a 4-phase REQ/ACK handshake on PIO wires. It is the FPGA-initiated counterpart of the HPS-polled address/data read path. The HPS raises START, and the block walks the RAM and sends the following, one word per handshake:

- a header word,
- COLS column words,
- ROWS row words,
- a checksum word.

It sits between the projection accumulator RAMs and the Qsys PIO exports.

## Interface
- COLS, 640, number of column entries sent (indices 0..COLS-1)
- ROWS, 480, number of row entries sent (indices 0..ROWS-1)
- VAL_W, 10, width of one RAM value (must be ≤20)
- SYNC_STAGES, 2, flip-flop stages on iSTART, iABORT and iACK
- iCLK  in  1  single clock, all state on rising edge
- iRST_N  in  1  reset, asynchronous, active-low
- iSTART  in  1  HPS PIO, level; a rising edge of the synchronized signal starts a transfer
- iABORT  in  1  HPS PIO, level; a synchronized high cancels the transfer
- iACK  in  1  HPS PIO handshake acknowledge, asynchronous
- oRAM_SEL  out  1  0 selects column RAM, 1 selects row RAM
- oRAM_ADDR  out  10  RAM read address
- iRAM_DATA  in  VAL_W  RAM read data, valid exactly 1 cycle after the address is presented
- oDATA  out  32  word format:
  - [31:30] kind: 00 header, 01 column, 10 row, 11 checksum
  - [29:20] index
  - [19:0] value, zero-extended
- oREQ  out  1  word valid / request
- oBUSY  out  1  high from start until return to IDLE or DONE
- oDONE  out  1  high in DONE
- oSTATE  out  3  state encoding, for LEDR debug

## Operation
- Reset values:
  - oDATA=0, oREQ=0, oBUSY=0, oDONE=0, oSTATE=IDLE(0)
  - oRAM_SEL=0, oRAM_ADDR=0
  - sequence counter=0, checksum=0
- States and encodings: IDLE(0), HDR(1), FETCH(2), RDWAIT(3), REQ_HI(4), REQ_LO(5), CSUM(6), DONE(7).
- IDLE/DONE → HDR on a rising edge of synced iSTART. Clear the checksum and index, set oRAM_SEL=0, assert oBUSY.
- HDR: load oDATA={2'b00,10'd0,seq[19:0]}, then go to REQ_HI.
- FETCH: drive oRAM_SEL and oRAM_ADDR=index, then go to RDWAIT.
- RDWAIT: capture iRAM_DATA and load oDATA={kind,index,zero-ext value}, add the value to the checksum, then go to REQ_HI.
- REQ_HI: oREQ=1, held until synced iACK=1, then oREQ=0 and go to REQ_LO. oDATA is stable for the whole period oREQ is high.
- REQ_LO: wait for synced iACK=0, then choose the next word:
  - if the last word was the checksum, go to DONE;
  - if a column word with index COLS-1 was just sent, set index=0, oRAM_SEL=1, go to FETCH;
  - if a row word with index ROWS-1 was just sent, go to CSUM;
  - otherwise increment index and go to FETCH. A header is followed by FETCH at index 0.
- CSUM: load oDATA={2'b11,10'd0,checksum[19:0]}, then go to REQ_HI.
- Checksum: 20-bit sum modulo 2^20 over all COLS+ROWS values. The header is excluded.
- DONE:
  - oDONE=1, oBUSY=0, seq increments once on entry (wraps at 2^20);
  - DONE → IDLE when synced iSTART=0.
- Abort: synced iABORT=1 in any state other than IDLE forces oREQ=0, oBUSY=0, go to IDLE. seq is not incremented. Abort has priority over every other transition in the same cycle.
- A rising edge of iSTART while oBUSY=1 is ignored. Holding iSTART high after DONE does not restart; a new rising edge is required.
- iACK already high on entry to REQ_HI: the handshake completes on the next cycle. The protocol stays 4-phase; ACK must have returned low in REQ_LO first.

## Timing
- Synchronizer latency is SYNC_STAGES cycles on each async input.
- Start: from the iSTART edge reaching the synchronizer output, HDR takes 1 cycle and oREQ rises the next cycle.
- Per data word with zero-latency ACK: FETCH 1 + RDWAIT 1 + REQ_HI ≥(1+SYNC_STAGES) + REQ_LO ≥(1+SYNC_STAGES) cycles.
- oREQ deasserts in the same cycle synced iACK is seen high.
- Full transfer is COLS+ROWS+2 handshakes; with defaults, 1122 words.
- Asynchronous reset mid-transfer: all outputs return to reset values immediately, with no completion word.

## Structure
- Shared package (proj_pkg): COLS and ROWS defaults, kind codes (KIND_HDR/COL/ROW/CSUM), state enum, word field positions.
- Sub-module sync_bit (SYNC_STAGES-deep, reset to 0), instantiated 3 times.
- The remainder is a single FSM module.

## Test plan
- Reset with iACK echoing oREQ after 3 cycles and RAM col[i]=i, row[j]=j:
  - words: header seq=0; col words 0..639 with value=index; row words 0..479;
  - checksum = (204480+114960) mod 2^20 = 319440;
  - oDONE=1 and seq becomes 1.
- iACK stuck low after the 5th word's REQ: oREQ stays high and oDATA is stable for 1000 cycles; releasing iACK resumes at word 6 with no duplicate or skip.
- All values 1023 (max): checksum = 1120·1023 mod 2^20 = 97184 (wraps correctly), and every value field is 0x003FF.
- iABORT asserted during a row word with oREQ high: oREQ falls within SYNC_STAGES+1 cycles, state is IDLE, seq unchanged. The next start sends header seq equal to the previous value.
- Extra iSTART pulse mid-transfer: ignored, word count remains 1122. iSTART held high after DONE: no restart until it toggles low then high.
- iRST_N asserted asynchronously mid-word: all outputs go to 0 without waiting for a clock edge, and oSTATE reads 0.
